// File: rtl/bit_scan_seq.sv
// Sequential bit scanner: accepts a W-bit vector and emits one beat per matching bit.
// Define BIT_SCAN_SEQ_PIPELINE_EN to accept the next vector on the cycle its predecessor's last beat transfers.
module bit_scan_seq #(
  parameter int W                   = 32,
  parameter int D                   = $clog2(W),
  parameter bit OPT_FIND_FIRST_ZERO = 1'b0,
  parameter bit OPT_MSB_FIRST       = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_x,
  output logic         in_rdy,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [D-1:0] out_n,
  output logic [W-1:0] out_y,
  output logic         out_last,
  output logic         out_empty,
  output logic         busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_e;

  state_e       state_q;
  logic [W-1:0] pend_q, pend_d, load_d;
  logic         zflag_q;
  logic [W-1:0] sel_y;
  logic [D-1:0] sel_n;
  logic         one_left;
  logic         accept, xfer;

  // Zero mode scans the complement, so both modes share one set-bit scanner.
  assign load_d = OPT_FIND_FIRST_ZERO ? ~in_x : in_x;

  // The last set bit visited wins: ascending visit picks the highest, descending the lowest.
  always_comb begin
    sel_y = '0;
    sel_n = '0;
    if (OPT_MSB_FIRST) begin
      for (int i = 0; i < W; i++) begin
        if (pend_q[i]) begin
          sel_y    = '0;
          sel_y[i] = 1'b1;
          sel_n    = D'(i);
        end
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (pend_q[i]) begin
          sel_y    = '0;
          sel_y[i] = 1'b1;
          sel_n    = D'(i);
        end
      end
    end
  end

  assign one_left  = (pend_q != '0) && ((pend_q & (pend_q - W'(1))) == '0);

  assign out_vld   = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign out_y     = (out_vld && !zflag_q) ? sel_y : '0;
  assign out_n     = (out_vld && !zflag_q) ? sel_n : '0;
  assign out_last  = out_vld & (zflag_q | one_left);
  assign out_empty = out_vld & zflag_q;

`ifdef BIT_SCAN_SEQ_PIPELINE_EN
  assign in_rdy = (state_q == IDLE) | (out_vld & out_rdy & out_last);
`else
  assign in_rdy = (state_q == IDLE);
`endif

  assign accept = in_vld & in_rdy;
  assign xfer   = out_vld & out_rdy;
  assign pend_d = pend_q & ~out_y;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is only sampled here on the clock edge.
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      zflag_q <= 1'b0;
    end else begin
      if (xfer) begin
        pend_q <= pend_d;
        if (out_last) begin
          state_q <= IDLE;
          zflag_q <= 1'b0;
        end
      end
      // NOTE: with non-blocking assignments the later acceptance overrides the retire above.
      if (accept) begin
        pend_q  <= load_d;
        zflag_q <= (load_d == '0);
        state_q <= EMIT;
      end
    end
  end

endmodule

// File: tb/tb_bit_scan_seq.sv
// Directed bench for bit_scan_seq: LSB/MSB order, zero mode, odd width, backpressure, reset abort.
// Expectations for the last-beat in_rdy follow BIT_SCAN_SEQ_PIPELINE_EN when it is defined.
module tb_bit_scan_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Main instance: W=8, LSB first, set bits.
  logic       a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_out_last, a_out_empty, a_busy;
  logic [7:0] a_in_x, a_out_y;
  logic [2:0] a_out_n;
  // Zero mode.
  logic       z_in_vld, z_in_rdy, z_out_vld, z_out_rdy, z_out_last, z_out_empty, z_busy;
  logic [7:0] z_in_x, z_out_y;
  logic [2:0] z_out_n;
  // MSB first.
  logic       m_in_vld, m_in_rdy, m_out_vld, m_out_rdy, m_out_last, m_out_empty, m_busy;
  logic [7:0] m_in_x, m_out_y;
  logic [2:0] m_out_n;
  // Non power-of-two width.
  logic       s_in_vld, s_in_rdy, s_out_vld, s_out_rdy, s_out_last, s_out_empty, s_busy;
  logic [5:0] s_in_x, s_out_y;
  logic [2:0] s_out_n;

  bit_scan_seq #(.W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_vld(a_in_vld), .in_x(a_in_x), .in_rdy(a_in_rdy),
    .out_vld(a_out_vld), .out_rdy(a_out_rdy), .out_n(a_out_n), .out_y(a_out_y),
    .out_last(a_out_last), .out_empty(a_out_empty), .busy(a_busy));

  bit_scan_seq #(.W(8), .OPT_FIND_FIRST_ZERO(1'b1)) u_z (
    .clk(clk), .rst_n(rst_n), .in_vld(z_in_vld), .in_x(z_in_x), .in_rdy(z_in_rdy),
    .out_vld(z_out_vld), .out_rdy(z_out_rdy), .out_n(z_out_n), .out_y(z_out_y),
    .out_last(z_out_last), .out_empty(z_out_empty), .busy(z_busy));

  bit_scan_seq #(.W(8), .OPT_MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst_n(rst_n), .in_vld(m_in_vld), .in_x(m_in_x), .in_rdy(m_in_rdy),
    .out_vld(m_out_vld), .out_rdy(m_out_rdy), .out_n(m_out_n), .out_y(m_out_y),
    .out_last(m_out_last), .out_empty(m_out_empty), .busy(m_busy));

  bit_scan_seq #(.W(6)) u_s (
    .clk(clk), .rst_n(rst_n), .in_vld(s_in_vld), .in_x(s_in_x), .in_rdy(s_in_rdy),
    .out_vld(s_out_vld), .out_rdy(s_out_rdy), .out_n(s_out_n), .out_y(s_out_y),
    .out_last(s_out_last), .out_empty(s_out_empty), .busy(s_busy));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [2:0] n, input logic [7:0] y,
                            input logic last, input logic [2:0] en, input logic [7:0] ey,
                            input logic elast);
    check({tag, "_n"}, 32'(n), 32'(en));
    check({tag, "_y"}, 32'(y), 32'(ey));
    check({tag, "_last"}, 32'(last), 32'(elast));
  endtask

  bit exp_pipe_rdy;

  initial begin
`ifdef BIT_SCAN_SEQ_PIPELINE_EN
    exp_pipe_rdy = 1'b1;
`else
    exp_pipe_rdy = 1'b0;
`endif
    rst_n = 1'b0;
    {a_in_vld, z_in_vld, m_in_vld, s_in_vld} = '0;
    {a_out_rdy, z_out_rdy, m_out_rdy, s_out_rdy} = '1;
    a_in_x = 8'h00; z_in_x = 8'h00; m_in_x = 8'h00; s_in_x = 6'h00;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state.
    check("rst_in_rdy", 32'(a_in_rdy), 1);
    check("rst_out_vld", 32'(a_out_vld), 0);
    check("rst_out_n", 32'(a_out_n), 0);
    check("rst_out_y", 32'(a_out_y), 0);
    check("rst_out_last", 32'(a_out_last), 0);
    check("rst_out_empty", 32'(a_out_empty), 0);
    check("rst_busy", 32'(a_busy), 0);

    // 0xA4 LSB first: beats 2, 5, 7.
    a_in_x = 8'hA4; a_in_vld = 1'b1;
    tick();
    a_in_vld = 1'b0; a_in_x = 8'h5B;
    check("a4_c1_vld", 32'(a_out_vld), 1);
    check("a4_c1_busy", 32'(a_busy), 1);
    check("a4_c1_in_rdy", 32'(a_in_rdy), 0);
    check_beat("a4_c1", a_out_n, a_out_y, a_out_last, 3'd2, 8'h04, 1'b0);
    tick();
    check_beat("a4_c2", a_out_n, a_out_y, a_out_last, 3'd5, 8'h20, 1'b0);
    tick();
    check_beat("a4_c3", a_out_n, a_out_y, a_out_last, 3'd7, 8'h80, 1'b1);
    check("a4_c3_in_rdy", 32'(a_in_rdy), 32'(exp_pipe_rdy));
    check("a4_c3_empty", 32'(a_out_empty), 0);
    tick();
    check("a4_c4_vld", 32'(a_out_vld), 0);
    check("a4_c4_in_rdy", 32'(a_in_rdy), 1);
    check("a4_c4_busy", 32'(a_busy), 0);
    check("a4_c4_y", 32'(a_out_y), 0);

    // Empty vector: one beat flagged empty.
    a_in_x = 8'h00; a_in_vld = 1'b1;
    tick();
    a_in_vld = 1'b0;
    check("e_vld", 32'(a_out_vld), 1);
    check("e_empty", 32'(a_out_empty), 1);
    check_beat("e", a_out_n, a_out_y, a_out_last, 3'd0, 8'h00, 1'b1);
    tick();
    check("e_idle_vld", 32'(a_out_vld), 0);
    check("e_idle_busy", 32'(a_busy), 0);

    // 0x24 with out_rdy low for cycles 1-3.
    a_in_x = 8'h24; a_in_vld = 1'b1; a_out_rdy = 1'b0;
    tick();
    a_in_vld = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check_beat($sformatf("bp_c%0d", c), a_out_n, a_out_y, a_out_last, 3'd2, 8'h04, 1'b0);
      check($sformatf("bp_c%0d_vld", c), 32'(a_out_vld), 1);
      a_in_x = 8'hFF;
      tick();
    end
    a_out_rdy = 1'b1;
    check_beat("bp_c4", a_out_n, a_out_y, a_out_last, 3'd2, 8'h04, 1'b0);
    tick();
    check_beat("bp_c5", a_out_n, a_out_y, a_out_last, 3'd5, 8'h20, 1'b1);
    tick();
    check("bp_c6_vld", 32'(a_out_vld), 0);

    // 0xFF aborted by reset after the third beat.
    a_in_x = 8'hFF; a_in_vld = 1'b1;
    tick();
    a_in_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_beat($sformatf("ff_b%0d", c), a_out_n, a_out_y, a_out_last, 3'(c), 8'(1 << c), 1'b0);
      tick();
    end
    check("ff_b3_n", 32'(a_out_n), 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("ab_vld", 32'(a_out_vld), 0);
    check("ab_busy", 32'(a_busy), 0);
    check("ab_in_rdy", 32'(a_in_rdy), 1);
    a_in_x = 8'h10; a_in_vld = 1'b1;
    tick();
    a_in_vld = 1'b0;
    check_beat("ab_10", a_out_n, a_out_y, a_out_last, 3'd4, 8'h10, 1'b1);
    tick();
    check("ab_10_idle", 32'(a_out_vld), 0);

    // Zero mode: 0xFE has only bit 0 clear.
    z_in_x = 8'hFE; z_in_vld = 1'b1;
    tick();
    z_in_vld = 1'b0;
    check("z_vld", 32'(z_out_vld), 1);
    check("z_empty", 32'(z_out_empty), 0);
    check_beat("z", z_out_n, z_out_y, z_out_last, 3'd0, 8'h01, 1'b1);
    tick();
    check("z_idle", 32'(z_out_vld), 0);

    // MSB first: 0x81 gives 7 then 0.
    m_in_x = 8'h81; m_in_vld = 1'b1;
    tick();
    m_in_vld = 1'b0;
    check_beat("m_b0", m_out_n, m_out_y, m_out_last, 3'd7, 8'h80, 1'b0);
    tick();
    check_beat("m_b1", m_out_n, m_out_y, m_out_last, 3'd0, 8'h01, 1'b1);
    tick();
    check("m_idle", 32'(m_out_vld), 0);

    // W=6, all ones: six beats 0..5.
    s_in_x = 6'h3F; s_in_vld = 1'b1;
    tick();
    s_in_vld = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("s_b%0d_n", c), 32'(s_out_n), 32'(c));
      check($sformatf("s_b%0d_y", c), 32'(s_out_y), 32'(1 << c));
      check($sformatf("s_b%0d_last", c), 32'(s_out_last), 32'(c == 5));
      tick();
    end
    check("s_idle", 32'(s_out_vld), 0);
    check("s_in_rdy", 32'(s_in_rdy), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_scan_seq.md
Name: bit_scan_seq

Overview:
- Sequential, parametrised successor to the combinational find-first-set.
- Accepts a W-bit vector over a valid/ready handshake.
- Emits the index and one-hot of every matching bit (set, or clear in zero mode), one per cycle, in a programmable scan order.
- Used by arbiters, free-list allocators and interrupt dispatch, where all pending bits must be serviced, not just the first.

Parameters:
- W, 32: vector width; W >= 2, need not be a power of two.
- D, $clog2(W): index width; derived, not overridden.
- OPT_FIND_FIRST_ZERO, 0: 1 = scan for clear bits (internally operates on ~x).
- OPT_MSB_FIRST, 0: 1 = emit highest index first; 0 = lowest index first.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_vld  input  1  input vector valid.
- in_x  input  W  vector to scan.
- in_rdy  output  1  block can accept a vector.
- out_vld  output  1  output beat valid.
- out_rdy  input  1  consumer accepts beat.
- out_n  output  D  index of current matching bit.
- out_y  output  W  one-hot of current matching bit.
- out_last  output  1  final beat for this vector.
- out_empty  output  1  vector had no matching bits.
- busy  output  1  scan in progress (state != IDLE).

Behaviour:
- One clock; reset is synchronous, active-low.
- Registers:
  - state ∈ {IDLE, EMIT}.
  - pend[W-1:0]: remaining matching bits.
  - zflag: vector was empty.
- Reset (rst_n=0 at an edge) forces state=IDLE, pend=0, zflag=0, regardless of current activity. A scan in progress is abandoned with no further beats.
- Reset values of outputs, following the edge:
  - in_rdy=1.
  - out_vld=0, out_n=0, out_y=0, out_last=0, out_empty=0, busy=0.
- IDLE:
  - in_rdy=1, out_vld=0.
  - On in_vld && in_rdy:
    - pend <= OPT_FIND_FIRST_ZERO ? ~in_x : in_x.
    - zflag <= (that value == 0).
    - state <= EMIT.
- EMIT:
  - in_rdy=0, out_vld=1, busy=1.
  - sel = lowest set bit of pend (OPT_MSB_FIRST=0) or highest set bit (=1).
  - out_y = one-hot of sel; out_n = sel.
  - out_last = zflag | (pend has exactly one bit set).
  - out_empty = zflag.
  - When zflag=1: out_n=0, out_y=0, exactly one beat is emitted.
- Transfer on out_vld && out_rdy:
  - pend <= pend & ~out_y.
  - If out_last: state <= IDLE, zflag <= 0.
- Timing:
  - First beat is valid the cycle after input acceptance.
  - One beat per cycle while out_rdy=1.
  - A vector with k matching bits occupies k+1 cycles from acceptance to return to IDLE; an empty vector occupies 2 cycles.
- Backpressure: while out_vld && !out_rdy, out_n/out_y/out_last/out_empty stay stable and pend is unchanged.
- Output encoding:
  - out_n/out_y are combinational from pend/zflag.
  - They are 0 in IDLE.
  - out_n is always < W.
- in_x is ignored unless in_vld && in_rdy.
- No internal queue: a vector offered while in_rdy=0 waits in the producer.

Optional Feature:
- Macro: BIT_SCAN_SEQ_PIPELINE_EN.
- Defined:
  - in_rdy = (state==IDLE) | (out_vld & out_rdy & out_last).
  - A new vector is accepted in the same cycle the last beat transfers. pend/zflag reload directly and state stays EMIT, giving zero-bubble back-to-back scans.
  - in_rdy is then combinationally dependent on out_rdy.
- Undefined: in_rdy = (state==IDLE) only; one bubble cycle between vectors.

Test Plan:
- W=8, LSB-first, out_rdy=1, in_x=8'hA4 accepted at cycle 0:
  - Beats at cycles 1,2,3 with out_n=2,5,7 and out_y=8'h04,8'h20,8'h80.
  - out_last only at cycle 3.
  - in_rdy=1 at cycle 4; with BIT_SCAN_SEQ_PIPELINE_EN, in_rdy=1 at cycle 3.
- W=8, in_x=8'h00: single beat with out_empty=1, out_last=1, out_n=0, out_y=0; then IDLE.
- W=8, in_x=8'h24, out_rdy=0 for cycles 1-3: out_n=2 and out_y=8'h04 stable across those cycles. Beats n=2 then n=5 after out_rdy rises; no beat lost or duplicated.
- W=8, OPT_FIND_FIRST_ZERO=1, in_x=8'hFE: one beat, out_n=0, out_y=8'h01, out_last=1, out_empty=0.
- W=8, OPT_MSB_FIRST=1, in_x=8'h81: beats n=7 then n=0. Separately, W=6 with in_x=6'h3F gives 6 beats n=0..5.
- W=8, in_x=8'hFF, rst_n=0 after the third beat: next cycle out_vld=0, busy=0, in_rdy=1. A following in_x=8'h10 yields a single beat n=4.
